apb_req_arbiter: RTL

- Shares the single APB_Master request port (transfer/ready/addr/wdata/write/rdata) between two bus requesters: req0 = RV32I core data port, req1 = future DMA/bridge.
- Sits between the requesters and APB_Master in MCU.
- Serializes transactions, one in flight at a time.
- Arbitration is round-robin or fixed-priority; results are routed back to the granted requester only.

---
 rtl/apb_arb_pkg.sv | 16 +
 rtl/arb_rr2.sv | 23 ++
 rtl/apb_req_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB request arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } arb_state_e;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT0     = 2'b01;
   localparam logic [1:0] GNT1     = 2'b10;

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way picker: round-robin on ties when RR_EN, else req_i[0] always wins ties.
module arb_rr2
   import apb_arb_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = GNT_NONE;
      unique case (req_i)
         2'b01:   gnt_o = GNT0;
         2'b10:   gnt_o = GNT1;
         // last_grant_i = 1 means req1 was served last, so req0 takes the tie.
         2'b11:   gnt_o = (RR_EN && !last_grant_i) ? GNT1 : GNT0;
         default: gnt_o = GNT_NONE;
      endcase
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB_Master request port between two requesters, one transaction in flight.
// Defining ARB_TIMEOUT_EN adds a completion watchdog with a sticky timeout_err flag.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter bit RR_EN = 1'b1
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        req0_transfer,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic        req0_write,
   output logic        req0_ready,
   output logic [31:0] req0_rdata,
   input  logic        req1_transfer,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic        req1_write,
   output logic        req1_ready,
   output logic [31:0] req1_rdata,
   output logic        m_transfer,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_write,
   input  logic        m_ready,
   input  logic [31:0] m_rdata,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        timeout_err
);

   arb_state_e  state_q;
   logic [1:0]  grant_q;
   logic        last_grant_q;
   logic        m_transfer_q;
   logic        m_write_q;
   logic        busy_q;
   logic [31:0] m_addr_q;
   logic [31:0] m_wdata_q;
   logic [1:0]  winner;
   logic        done;
   logic        timeout_hit;
   logic [31:0] resp_rdata;

   arb_rr2 #(
      .RR_EN(RR_EN)
   ) u_pick (
      .req_i       ({req1_transfer, req0_transfer}),
      .last_grant_i(last_grant_q),
      .gnt_o       (winner)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q;
   logic            timeout_err_q;

   assign timeout_hit = (state_q == WAIT) && !m_ready && (cnt_q == CntW'(TIMEOUT_CYCLES));
   assign resp_rdata  = timeout_hit ? TIMEOUT_RDATA : m_rdata;
   assign timeout_err = timeout_err_q;

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (state_q == ISSUE) begin
            cnt_q <= '0;
         end else if ((state_q == WAIT) && !m_ready && !timeout_hit) begin
            cnt_q <= cnt_q + CntW'(1);
         end
         if (timeout_hit) begin
            timeout_err_q <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign resp_rdata  = m_rdata;
   assign timeout_err = 1'b0;
`endif

   // Completion is combinational so the requester sees ready in the same cycle as m_ready.
   assign done       = (state_q == WAIT) && (m_ready || timeout_hit);
   assign req0_ready = done && grant_q[0];
   assign req1_ready = done && grant_q[1];
   assign req0_rdata = req0_ready ? resp_rdata : '0;
   assign req1_rdata = req1_ready ? resp_rdata : '0;

   assign m_transfer = m_transfer_q;
   assign m_addr     = m_addr_q;
   assign m_wdata    = m_wdata_q;
   assign m_write    = m_write_q;
   assign grant      = grant_q;
   assign busy       = busy_q;

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q      <= IDLE;
         grant_q      <= GNT_NONE;
         last_grant_q <= 1'b1;
         m_transfer_q <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_write_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         m_transfer_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (winner != GNT_NONE) begin
                  grant_q      <= winner;
                  m_addr_q     <= winner[1] ? req1_addr  : req0_addr;
                  m_wdata_q    <= winner[1] ? req1_wdata : req0_wdata;
                  m_write_q    <= winner[1] ? req1_write : req0_write;
                  m_transfer_q <= 1'b1;
                  busy_q       <= 1'b1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (done) begin
                  last_grant_q <= grant_q[1];
                  grant_q      <= GNT_NONE;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
